// File: rtl/ofdm_pkg.sv
// ============================================================================
// ofdm_pkg : shared constants and state encodings for the OFDM result UART
// Revision : 1.0
// ============================================================================
`default_nettype none

package ofdm_pkg;

    localparam logic [7:0] FRAME_HDR      = 8'hA5;
    localparam logic [3:0] FRAME_LEN_BASE = 4'd14;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_SEND = 1'b1
    } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// uart_tx_byte : 8N1 serialiser with a valid/ready byte handshake
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_tx_byte
    import ofdm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == TX_IDLE || bit_end) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        case (state_q)
            TX_IDLE: ;
            TX_START: if (bit_end) begin
                state_d = TX_DATA;
                txd_d   = shreg_q[0];
            end
            TX_DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
                    state_d = TX_STOP;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shreg_d = shreg_q >> 1;
                    txd_d   = shreg_q[1];
                end
            end
            TX_STOP: if (bit_end) begin
                state_d = TX_IDLE;
                txd_d   = 1'b1;
            end
            default: state_d = TX_IDLE;
        endcase
        // A byte offered in the last stop-bit cycle starts with no idle gap
        if (valid_i && ready_o) begin
            state_d = TX_START;
            baud_d  = '0;
            bit_d   = '0;
            shreg_d = data_i;
            txd_d   = 1'b0;
        end
    end

    always_comb begin
        ready_o = (state_q == TX_IDLE) || (state_q == TX_STOP && bit_end);
        txd_o   = txd_q;
    end

endmodule

`default_nettype wire

// File: rtl/ofdm_result_uart.sv
// ============================================================================
// ofdm_result_uart : frames a demodulator result and sends it over UART 8N1.
// Optional checksum byte when OFDM_UART_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ofdm_result_uart
    import ofdm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        finish,
    input  logic        success,
    input  logic [95:0] res,
    output logic        txd,
    output logic        busy,
    output logic        dropped
);

`ifdef OFDM_UART_CHECKSUM_EN
    localparam logic [3:0] FRAME_LEN = FRAME_LEN_BASE + 4'd1;
`else
    localparam logic [3:0] FRAME_LEN = FRAME_LEN_BASE;
`endif

    frame_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [95:0]  res_q, res_d;
    logic         success_q, success_d;
    logic         dropped_q, dropped_d;
    logic         tx_valid, tx_ready;
    logic [7:0]   tx_byte, frame_byte;

`ifdef OFDM_UART_CHECKSUM_EN
    logic [7:0] chk;
    always_comb begin
        chk = FRAME_HDR ^ {7'b0, success_q};
        for (int i = 0; i < 12; i++) chk = chk ^ res_q[8*i +: 8];
    end
`endif

    // idx_q names the next byte to hand to the serialiser
    always_comb begin
        frame_byte = FRAME_HDR;
        if (idx_q == 4'd1) frame_byte = {7'b0, success_q};
        for (int i = 0; i < 12; i++)
            if (idx_q == 4'(i + 2)) frame_byte = res_q[95-8*i -: 8];
`ifdef OFDM_UART_CHECKSUM_EN
        if (idx_q == FRAME_LEN_BASE) frame_byte = chk;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FR_IDLE;
            idx_q     <= '0;
            res_q     <= '0;
            success_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            res_q     <= res_d;
            success_q <= success_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        res_d     = res_q;
        success_d = success_q;
        dropped_d = 1'b0;
        case (state_q)
            FR_IDLE: if (finish) begin
                state_d   = FR_SEND;
                idx_d     = 4'd1;
                res_d     = res;
                success_d = success;
            end
            FR_SEND: begin
                dropped_d = finish;
                if (tx_ready) begin
                    if (idx_q == FRAME_LEN) begin
                        state_d = FR_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    // Header goes out straight from the capture cycle to meet one-clock latency
    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = frame_byte;
        case (state_q)
            FR_IDLE: begin
                tx_valid = finish;
                tx_byte  = FRAME_HDR;
            end
            FR_SEND: tx_valid = tx_ready && (idx_q != FRAME_LEN);
            default: tx_valid = 1'b0;
        endcase
        busy    = (state_q == FR_SEND);
        dropped = dropped_q;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(tx_valid),
        .data_i (tx_byte),
        .ready_o(tx_ready),
        .txd_o  (txd)
    );

endmodule

`default_nettype wire

// File: tb/tb_ofdm_result_uart.sv
// ============================================================================
// tb_ofdm_result_uart : randomized self-checking bench for ofdm_result_uart
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ofdm_result_uart;

    localparam int CPB_F = 4;
    localparam int CPB_S = 234;
`ifdef OFDM_UART_CHECKSUM_EN
    localparam int FLEN = 15;
`else
    localparam int FLEN = 14;
`endif
    localparam int NF = FLEN * 10 * CPB_F;
    localparam int NS = FLEN * 10 * CPB_S;
    localparam logic [95:0] KNOWN_RES = 96'h55_0123456789ABCDEF0123_55;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        finish = 1'b0;
    logic        success = 1'b0;
    logic [95:0] res = '0;
    logic        txd, busy, dropped;
    logic        finish_s = 1'b0;
    logic        success_s = 1'b0;
    logic [95:0] res_s = '0;
    logic        txd_s, busy_s, dropped_s;

    int errors = 0;
    int checks = 0;

    logic       obs_txd  [NF];
    logic       obs_busy [NF];
    logic       obs_drop [NF];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ofdm_result_uart #(.CLKS_PER_BIT(CPB_F)) dut (
        .clk(clk), .rst_n(rst_n), .finish(finish), .success(success), .res(res),
        .txd(txd), .busy(busy), .dropped(dropped)
    );

    ofdm_result_uart dut_slow (
        .clk(clk), .rst_n(rst_n), .finish(finish_s), .success(success_s), .res(res_s),
        .txd(txd_s), .busy(busy_s), .dropped(dropped_s)
    );

    // Reference frame: header, status, payload MSB byte first, optional XOR
    function automatic void build_model(input bit s, input logic [95:0] r);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back({7'b0, s});
        for (int i = 0; i < 12; i++) exp_q.push_back(r[95-8*i -: 8]);
`ifdef OFDM_UART_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 14; i++) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endfunction

    function automatic logic exp_txd(input int k, input int cpb);
        int b, by, p;
        logic [7:0] v;
        b  = k / cpb;
        by = b / 10;
        p  = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        v = exp_q[by];
        return v[p-1];
    endfunction

    function automatic int wave_mismatch();
        int m = 0;
        for (int k = 0; k < NF; k++) if (obs_txd[k] !== exp_txd(k, CPB_F)) m++;
        return m;
    endfunction

    function automatic logic [7:0] decode_byte(input int j);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = obs_txd[(j*10 + 1 + i)*CPB_F + CPB_F/2];
        return v;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int k = 0; k < NF; k++) if (obs_busy[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_drop();
        int n = 0;
        for (int k = 0; k < NF; k++) if (obs_drop[k] === 1'b1) n++;
        return n;
    endfunction

    // Called at a negedge: that cycle is the capture cycle; records NF cycles after it
    task automatic capture_fast(input bit s, input logic [95:0] r, input int second_at);
        finish  = 1'b1;
        success = s;
        res     = r;
        @(negedge clk);
        finish  = 1'b0;
        success = 1'($urandom & 1);
        res     = {$urandom, $urandom, $urandom};
        for (int k = 0; k < NF; k++) begin
            obs_txd[k]  = txd;
            obs_busy[k] = busy;
            obs_drop[k] = dropped;
            if (k == second_at) begin
                finish  = 1'b1;
                success = 1'b1;
                res     = {$urandom, $urandom, $urandom};
            end else begin
                finish  = 1'b0;
            end
            @(negedge clk);
        end
        finish = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; finish = 1'b1; success = 1'b1; res = KNOWN_RES;
        finish_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
        checks++; if (txd_s !== 1'b1 || busy_s !== 1'b0 || dropped_s !== 1'b0) begin
            errors++; $display("FAIL reset_slow: got txd=%b busy=%b dropped=%b expected 1 0 0", txd_s, busy_s, dropped_s);
        end
        rst_n = 1'b1; finish = 1'b0; finish_s = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || txd_s !== 1'b1 || busy_s !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_release_idle: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_frames();
        bit s;
        logic [95:0] r;
        logic [7:0] d;
        int m;
        for (int t = 0; t < 5; t++) begin
            case (t)
                0: begin s = 1'b1; r = KNOWN_RES; end
                1: begin s = 1'b0; r = '0; end
                default: begin s = 1'($urandom & 1); r = {$urandom, $urandom, $urandom}; end
            endcase
            build_model(s, r);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame%0d_idle_before: got busy=%b expected 0", t, busy); end
            capture_fast(s, r, -1);
            m = wave_mismatch();
            checks++; if (m != 0) begin errors++; $display("FAIL frame%0d_waveform: got %0d bad cycles expected 0", t, m); end
            for (int j = 0; j < FLEN; j++) begin
                d = decode_byte(j);
                checks++; if (d !== exp_q[j]) begin errors++; $display("FAIL frame%0d_byte%0d: got %h expected %h", t, j, d, exp_q[j]); end
            end
`ifdef OFDM_UART_CHECKSUM_EN
            if (t == 1) begin
                d = decode_byte(14);
                checks++; if (d !== 8'hA5) begin errors++; $display("FAIL zero_checksum: got %h expected a5", d); end
            end
`endif
            m = count_busy();
            checks++; if (m != NF) begin errors++; $display("FAIL frame%0d_busy_len: got %0d expected %0d", t, m, NF); end
            checks++; if (busy !== 1'b0 || txd !== 1'b1) begin
                errors++; $display("FAIL frame%0d_end_idle: got busy=%b txd=%b expected 0 1", t, busy, txd);
            end
            m = count_drop();
            checks++; if (m != 0) begin errors++; $display("FAIL frame%0d_no_drop: got %0d pulses expected 0", t, m); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_drop();
        logic [95:0] r;
        int m, first;
        r = {$urandom, $urandom, $urandom};
        build_model(1'b1, r);
        capture_fast(1'b1, r, 250);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL drop_first_frame: got %0d bad cycles expected 0", m); end
        m = count_drop();
        checks++; if (m != 1) begin errors++; $display("FAIL drop_pulses: got %0d expected 1", m); end
        first = -1;
        for (int k = NF - 1; k >= 0; k--) if (obs_drop[k] === 1'b1) first = k;
        checks++; if (first <= 250 || first > 252) begin errors++; $display("FAIL drop_timing: got cycle %0d expected 251..252", first); end
        m = 0;
        repeat (60) begin
            if (busy !== 1'b0 || txd !== 1'b1) m++;
            @(negedge clk);
        end
        checks++; if (m != 0) begin errors++; $display("FAIL drop_no_resend: got %0d active cycles expected 0", m); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] ra, rb;
        bit sb;
        int m;
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom};
        sb = 1'($urandom & 1);
        build_model(1'b0, ra);
        capture_fast(1'b0, ra, -1);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL b2b_first: got %0d bad cycles expected 0", m); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b expected 0", busy); end
        build_model(sb, rb);
        capture_fast(sb, rb, -1);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL b2b_second: got %0d bad cycles expected 0", m); end
        m = count_drop();
        checks++; if (m != 0) begin errors++; $display("FAIL b2b_dropped: got %0d pulses expected 0", m); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [95:0] r;
        int m;
        r = {$urandom, $urandom, $urandom};
        build_model(1'b1, r);
        finish = 1'b1; success = 1'b1; res = r;
        @(negedge clk);
        finish = 1'b0;
        repeat (5*10*CPB_F + 1) @(negedge clk);
        checks++; if (txd !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got txd=%b busy=%b expected 0 1", txd, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midreset_txd: got %b expected 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; finish = 1'b0;
        m = 0;
        repeat (80) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) m++;
        end
        checks++; if (m != 0) begin errors++; $display("FAIL midreset_no_resume: got %0d active cycles expected 0", m); end
        r = {$urandom, $urandom, $urandom};
        build_model(1'b0, r);
        capture_fast(1'b0, r, -1);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL midreset_recover: got %0d bad cycles expected 0", m); end
    endtask

    task automatic test_default_baud();
        logic [7:0] dec [FLEN];
        int m, nb, b, p;
        build_model(1'b1, KNOWN_RES);
        finish_s = 1'b1; success_s = 1'b1; res_s = KNOWN_RES;
        @(negedge clk);
        finish_s = 1'b0; success_s = 1'b0; res_s = '0;
        m = 0; nb = 0;
        for (int j = 0; j < FLEN; j++) dec[j] = 8'h00;
        for (int k = 0; k < NS; k++) begin
            if (txd_s !== exp_txd(k, CPB_S)) m++;
            if (busy_s === 1'b1) nb++;
            if (k % CPB_S == CPB_S/2) begin
                b = k / CPB_S;
                p = b % 10;
                if (p >= 1 && p <= 8) dec[b/10][p-1] = txd_s;
            end
            @(negedge clk);
        end
        checks++; if (m != 0) begin errors++; $display("FAIL slow_waveform: got %0d bad cycles expected 0", m); end
        checks++; if (nb != NS) begin errors++; $display("FAIL slow_busy_len: got %0d expected %0d", nb, NS); end
        checks++; if (busy_s !== 1'b0 || txd_s !== 1'b1) begin
            errors++; $display("FAIL slow_end_idle: got busy=%b txd=%b expected 0 1", busy_s, txd_s);
        end
        for (int j = 0; j < FLEN; j++) begin
            checks++; if (dec[j] !== exp_q[j]) begin errors++; $display("FAIL slow_byte%0d: got %h expected %h", j, dec[j], exp_q[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_default_baud();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
